// File: rtl/avst_tpg_source.sv
// avst_tpg_source
//   Avalon-ST video test-pattern generator. Every frame is one control packet
//   (header 0xF plus three beats carrying width, height and interlace) followed
//   by one video packet (header 0x0 plus WIDTH*HEIGHT 24-bit RGB pixels).
//   Ready latency is 0. All outputs come straight from registers.
//
// Parameters
//   WIDTH      active pixels per line (8..65535)
//   HEIGHT     active lines per frame (1..65535)
//   INTERLACE  interlace nibble carried in the control packet
//
// Ports
//   clk                 single clock, rising edge
//   reset               synchronous, active low
//   enable              frame enable, only looked at on frame boundaries
//   pattern_sel         0 bars, 1 solid, 2 ramp, 3 checker (latched at frame start)
//   solid_color         pixel value for the solid pattern (latched at frame start)
//   dout_data           beat data, {R,G,B}
//   dout_valid          beat valid
//   dout_startofpacket  first beat of a packet
//   dout_endofpacket    last beat of a packet
//   dout_ready          sink ready
//   frame_done          one-cycle pulse the cycle after the last pixel is accepted

module avst_tpg_source #(
   parameter int unsigned WIDTH     = 640,
   parameter int unsigned HEIGHT    = 480,
   parameter logic [3:0]  INTERLACE = 4'h3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_color,
   output logic [23:0] dout_data,
   output logic        dout_valid,
   output logic        dout_startofpacket,
   output logic        dout_endofpacket,
   input  logic        dout_ready,
   output logic        frame_done
);

   localparam logic [15:0] W16          = 16'(WIDTH);
   localparam logic [15:0] H16          = 16'(HEIGHT);
   localparam logic [15:0] LAST_X       = 16'(WIDTH - 1);
   localparam logic [15:0] LAST_Y       = 16'(HEIGHT - 1);
   // Bar width is a constant; the datapath only counts up to it.
   localparam logic [15:0] BARW         = 16'(WIDTH / 8);
   localparam logic [15:0] BAR_LAST_CNT = BARW - 16'd1;

   // Control packet payload: each 4-bit dimension nibble sits in the low
   // half of its own 8-bit symbol.
   localparam logic [23:0] CTRL_HDR_DATA = 24'h00000F;
   localparam logic [23:0] CTRL_B0_DATA  = {4'h0, W16[7:4], 4'h0, W16[11:8], 4'h0, W16[15:12]};
   localparam logic [23:0] CTRL_B1_DATA  = {4'h0, H16[11:8], 4'h0, H16[15:12], 4'h0, W16[3:0]};
   localparam logic [23:0] CTRL_B2_DATA  = {4'h0, INTERLACE, 4'h0, H16[3:0], 4'h0, H16[7:4]};
   localparam logic [23:0] VID_HDR_DATA  = 24'h000000;

   localparam logic [23:0] BAR_LUT [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CTRL_HDR,
      ST_CTRL_B0,
      ST_CTRL_B1,
      ST_CTRL_B2,
      ST_VID_HDR,
      ST_VID_PIX
   } state_t;

   state_t      state_reg;
   logic [23:0] data_reg;
   logic        valid_reg;
   logic        sop_reg;
   logic        eop_reg;
   logic        frame_done_reg;
   logic [15:0] x_reg;
   logic [15:0] y_reg;
   logic [15:0] bar_cnt_reg;
   logic [2:0]  bar_idx_reg;
   logic [1:0]  pattern_reg;
   logic [23:0] solid_reg;

   // Coordinates of the pixel that will be presented after the current beat
   // is accepted (pixel 0,0 when leaving the video header).
   logic [15:0] x_next;
   logic [15:0] y_next;
   logic [15:0] bar_cnt_next;
   logic [2:0]  bar_idx_next;
   logic        last_next;
   logic [23:0] ramp_pix;
   logic [23:0] pix_next;
   logic        accept;

   assign accept = valid_reg & dout_ready;

   always_comb begin
      x_next       = 16'd0;
      y_next       = 16'd0;
      bar_cnt_next = 16'd0;
      bar_idx_next = 3'd0;
      if (state_reg == ST_VID_PIX) begin
         if (x_reg == LAST_X) begin
            y_next = y_reg + 16'd1;
         end else begin
            x_next = x_reg + 16'd1;
            y_next = y_reg;
            if (bar_idx_reg == 3'd7) begin
               // Last bar absorbs the remainder of the line.
               bar_idx_next = bar_idx_reg;
               bar_cnt_next = bar_cnt_reg;
            end else if (bar_cnt_reg == BAR_LAST_CNT) begin
               bar_idx_next = bar_idx_reg + 3'd1;
            end else begin
               bar_idx_next = bar_idx_reg;
               bar_cnt_next = bar_cnt_reg + 16'd1;
            end
         end
      end
   end

   assign last_next = (x_next == LAST_X) && (y_next == LAST_Y);

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_ramp
         assign ramp_pix[gi*8 +: 8] = x_next[7:0];
      end
   endgenerate

   always_comb begin
      pix_next = 24'h000000;
      case (pattern_reg)
         2'd0:    pix_next = BAR_LUT[bar_idx_next];
         2'd1:    pix_next = solid_reg;
         2'd2:    pix_next = ramp_pix;
         default: pix_next = (x_next[4] ^ y_next[4]) ? 24'hFFFFFF : 24'h000000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         data_reg       <= 24'h000000;
         valid_reg      <= 1'b0;
         sop_reg        <= 1'b0;
         eop_reg        <= 1'b0;
         frame_done_reg <= 1'b0;
         x_reg          <= 16'd0;
         y_reg          <= 16'd0;
         bar_cnt_reg    <= 16'd0;
         bar_idx_reg    <= 3'd0;
         pattern_reg    <= 2'd0;
         solid_reg      <= 24'h000000;
      end else begin
         frame_done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (enable) begin
                  state_reg   <= ST_CTRL_HDR;
                  data_reg    <= CTRL_HDR_DATA;
                  valid_reg   <= 1'b1;
                  sop_reg     <= 1'b1;
                  eop_reg     <= 1'b0;
                  pattern_reg <= pattern_sel;
                  solid_reg   <= solid_color;
               end
            end
            ST_CTRL_HDR: begin
               if (accept) begin
                  state_reg <= ST_CTRL_B0;
                  data_reg  <= CTRL_B0_DATA;
                  sop_reg   <= 1'b0;
               end
            end
            ST_CTRL_B0: begin
               if (accept) begin
                  state_reg <= ST_CTRL_B1;
                  data_reg  <= CTRL_B1_DATA;
               end
            end
            ST_CTRL_B1: begin
               if (accept) begin
                  state_reg <= ST_CTRL_B2;
                  data_reg  <= CTRL_B2_DATA;
                  eop_reg   <= 1'b1;
               end
            end
            ST_CTRL_B2: begin
               if (accept) begin
                  state_reg <= ST_VID_HDR;
                  data_reg  <= VID_HDR_DATA;
                  sop_reg   <= 1'b1;
                  eop_reg   <= 1'b0;
               end
            end
            ST_VID_HDR: begin
               if (accept) begin
                  state_reg   <= ST_VID_PIX;
                  data_reg    <= pix_next;
                  sop_reg     <= 1'b0;
                  eop_reg     <= last_next;
                  x_reg       <= x_next;
                  y_reg       <= y_next;
                  bar_cnt_reg <= bar_cnt_next;
                  bar_idx_reg <= bar_idx_next;
               end
            end
            ST_VID_PIX: begin
               if (accept) begin
                  if (eop_reg) begin
                     frame_done_reg <= 1'b1;
                     x_reg          <= 16'd0;
                     y_reg          <= 16'd0;
                     bar_cnt_reg    <= 16'd0;
                     bar_idx_reg    <= 3'd0;
                     eop_reg        <= 1'b0;
                     if (enable) begin
                        // Back-to-back frames: no idle cycle between them.
                        state_reg   <= ST_CTRL_HDR;
                        data_reg    <= CTRL_HDR_DATA;
                        sop_reg     <= 1'b1;
                        pattern_reg <= pattern_sel;
                        solid_reg   <= solid_color;
                     end else begin
                        state_reg <= ST_IDLE;
                        data_reg  <= 24'h000000;
                        valid_reg <= 1'b0;
                        sop_reg   <= 1'b0;
                     end
                  end else begin
                     data_reg    <= pix_next;
                     eop_reg     <= last_next;
                     x_reg       <= x_next;
                     y_reg       <= y_next;
                     bar_cnt_reg <= bar_cnt_next;
                     bar_idx_reg <= bar_idx_next;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign dout_data          = data_reg;
   assign dout_valid         = valid_reg;
   assign dout_startofpacket = sop_reg;
   assign dout_endofpacket   = eop_reg;
   assign frame_done         = frame_done_reg;

endmodule

// File: tb/tb_avst_tpg_source.sv
// Bench for avst_tpg_source: three instances (640x480, 8x2, 20x2) exercised
// one at a time; a negedge monitor records accepted beats of the selected one.
module tb_avst_tpg_source;

   localparam int NI = 3;
   localparam logic [NI-1:0][15:0] WS = {16'd20, 16'd8, 16'd640};
   localparam logic [NI-1:0][15:0] HS = {16'd2,  16'd2, 16'd480};
   localparam logic [23:0] BARS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [NI];
   logic        en    [NI];
   logic        rdy   [NI];
   logic [1:0]  psel  [NI];
   logic [23:0] solid [NI];
   logic [23:0] dd    [NI];
   logic        dv    [NI];
   logic        dsop  [NI];
   logic        deop  [NI];
   logic        fd    [NI];

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         avst_tpg_source #(
            .WIDTH     (int'(WS[gi])),
            .HEIGHT    (int'(HS[gi])),
            .INTERLACE (4'h3)
         ) u_dut (
            .clk                (clk),
            .reset              (rst_n[gi]),
            .enable             (en[gi]),
            .pattern_sel        (psel[gi]),
            .solid_color        (solid[gi]),
            .dout_data          (dd[gi]),
            .dout_valid         (dv[gi]),
            .dout_startofpacket (dsop[gi]),
            .dout_endofpacket   (deop[gi]),
            .dout_ready         (rdy[gi]),
            .frame_done         (fd[gi])
         );
      end
   endgenerate

   typedef struct {
      logic [31:0] w;
      int          c;
   } beat_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          sel      = 0;
   int          cyc      = 0;
   beat_t       q[$];
   int          fdq[$];
   logic [31:0] expq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] mk(input logic s, input logic e, input logic [23:0] d);
      return {6'd0, s, e, d};
   endfunction

   function automatic logic [31:0] qw(input int i);
      if (i < q.size()) return q[i].w;
      return 32'hFFFF_FFFF;
   endfunction

   function automatic int qc(input int i);
      if (i < q.size()) return q[i].c;
      return -100;
   endfunction

   // Hand-computed control beats B0..B2 per instance.
   function automatic logic [23:0] ctrl_beat(input int inst, input int k);
      case (inst)
         0:       return (k == 0) ? 24'h080200 : (k == 1) ? 24'h010000 : 24'h03000E;
         1:       return (k == 0) ? 24'h000000 : (k == 1) ? 24'h000008 : 24'h030200;
         default: return (k == 0) ? 24'h010000 : (k == 1) ? 24'h000004 : 24'h030200;
      endcase
   endfunction

   function automatic logic [23:0] model_pix(input int w, input int x, input int y,
                                             input int pat, input logic [23:0] sc);
      logic [15:0] xv;
      logic [15:0] yv;
      int b;
      xv = 16'(x);
      yv = 16'(y);
      case (pat)
         0: begin
            b = x / (w / 8);
            if (b > 7) b = 7;
            return BARS[b];
         end
         1:       return sc;
         2:       return {xv[7:0], xv[7:0], xv[7:0]};
         default: return (xv[4] ^ yv[4]) ? 24'hFFFFFF : 24'h000000;
      endcase
   endfunction

   task automatic build_frame(input int inst, input int pat, input logic [23:0] sc);
      int w;
      int h;
      w = int'(WS[inst]);
      h = int'(HS[inst]);
      expq.push_back(mk(1'b1, 1'b0, 24'h00000F));
      for (int k = 0; k < 3; k++) expq.push_back(mk(1'b0, k == 2, ctrl_beat(inst, k)));
      expq.push_back(mk(1'b1, 1'b0, 24'h000000));
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            expq.push_back(mk(1'b0, (x == w - 1) && (y == h - 1), model_pix(w, x, y, pat, sc)));
   endtask

   task automatic compare_stream(input string tag, input bit exact);
      if (exact) check({tag, "_len"}, 32'(q.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size(); i++)
         check($sformatf("%s_beat%0d", tag, i), qw(i), expq[i]);
      expq.delete();
   endtask

   task automatic clear_mon();
      q.delete();
      fdq.delete();
   endtask

   task automatic run_until(input int n_fd, input int drop_at, input int budget, input bit rand_ready);
      int k;
      k = 0;
      while (fdq.size() < n_fd && k < budget) begin
         @(posedge clk); #1;
         k++;
         if (q.size() >= drop_at) en[sel] = 1'b0;
         if (rand_ready) rdy[sel] = 1'($urandom_range(0, 1));
      end
      rdy[sel] = 1'b1;
      check("frame_done_count", 32'(fdq.size()), 32'(n_fd));
   endtask

   // Monitor: accepted beats, frame_done pulses, stall hold and no mid-packet valid drop.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_word  = '0;
   logic        in_pkt     = 1'b0;

   always @(negedge clk) begin
      logic [31:0] cur;
      cur = mk(dsop[sel], deop[sel], dd[sel]);
      if (!rst_n[sel]) begin
         prev_stall = 1'b0;
         in_pkt     = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", 32'(dv[sel]), 32'd1);
            check("stall_beat_held", cur, prev_word);
         end
         if (in_pkt) check("valid_in_packet", 32'(dv[sel]), 32'd1);
         if (dv[sel] && rdy[sel]) begin
            q.push_back('{w: cur, c: cyc});
            if (dsop[sel]) in_pkt = 1'b1;
            if (deop[sel]) in_pkt = 1'b0;
         end
         if (fd[sel]) fdq.push_back(cyc);
         prev_stall = dv[sel] && !rdy[sel];
         prev_word  = cur;
      end
      cyc++;
   end

   initial begin
      for (int i = 0; i < NI; i++) begin
         rst_n[i] = 1'b0;
         en[i]    = 1'b0;
         rdy[i]   = 1'b1;
         psel[i]  = 2'd0;
         solid[i] = 24'h000000;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_valid%0d", i), 32'(dv[i]), 32'd0);
         check($sformatf("rst_data%0d", i), 32'(dd[i]), 32'd0);
         check($sformatf("rst_flags%0d", i), 32'({dsop[i], deop[i], fd[i]}), 32'd0);
      end

      // ---- 640x480: control beats, header, first ramp pixels ----
      sel = 0;
      clear_mon();
      rst_n[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("a_idle_valid", 32'(dv[0]), 32'd0);
      psel[0] = 2'd2;
      en[0]   = 1'b1;
      @(posedge clk); #1;
      check("a_start_valid", 32'(dv[0]), 32'd1);
      check("a_start_beat", mk(dsop[0], deop[0], dd[0]), mk(1'b1, 1'b0, 24'h00000F));
      repeat (12) @(posedge clk);
      #1;
      expq.push_back(mk(1'b1, 1'b0, 24'h00000F));
      expq.push_back(mk(1'b0, 1'b0, 24'h080200));
      expq.push_back(mk(1'b0, 1'b0, 24'h010000));
      expq.push_back(mk(1'b0, 1'b1, 24'h03000E));
      expq.push_back(mk(1'b1, 1'b0, 24'h000000));
      expq.push_back(mk(1'b0, 1'b0, 24'h000000));
      expq.push_back(mk(1'b0, 1'b0, 24'h010101));
      expq.push_back(mk(1'b0, 1'b0, 24'h020202));
      expq.push_back(mk(1'b0, 1'b0, 24'h030303));
      expq.push_back(mk(1'b0, 1'b0, 24'h040404));
      compare_stream("a640", 1'b0);
      check("a_consecutive", 32'(qc(9) - qc(0)), 32'd9);
      en[0]    = 1'b0;
      rst_n[0] = 1'b0;
      @(posedge clk); #1;

      // ---- 8x2 colour bars, single frame ----
      sel = 1;
      clear_mon();
      rst_n[1] = 1'b1;
      psel[1]  = 2'd0;
      en[1]    = 1'b1;
      run_until(1, 6, 200, 1'b0);
      check("b8_eop_valid_drop", 32'(dv[1]), 32'd0);
      check("b8_x1", qw(6),  mk(1'b0, 1'b0, 24'hFFFF00));
      check("b8_x4", qw(9),  mk(1'b0, 1'b0, 24'hFF00FF));
      check("b8_x7", qw(12), mk(1'b0, 1'b0, 24'h000000));
      check("b8_last", qw(20), mk(1'b0, 1'b1, 24'h000000));
      check("b8_fd_time", 32'(fdq.size() > 0 ? fdq[0] : -1), 32'(qc(20) + 1));
      build_frame(1, 0, 24'h0);
      compare_stream("b8", 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("b8_idle", 32'(dv[1]), 32'd0);
      check("b8_fd_single", 32'(fdq.size()), 32'd1);
      rst_n[1] = 1'b0;

      // ---- 20x2: bars over two back-to-back frames, enable dropped in frame 2 ----
      sel = 2;
      clear_mon();
      rst_n[2] = 1'b1;
      psel[2]  = 2'd0;
      @(posedge clk); #1;
      en[2] = 1'b1;
      @(posedge clk); #1;
      check("c_start_beat", mk(dsop[2], deop[2], dd[2]), mk(1'b1, 1'b0, 24'h00000F));
      run_until(2, 50, 400, 1'b0);
      check("c20_x13", qw(18), mk(1'b0, 1'b0, 24'h0000FF));
      check("c20_x14", qw(19), mk(1'b0, 1'b0, 24'h000000));
      check("c20_x19", qw(24), mk(1'b0, 1'b0, 24'h000000));
      check("c_no_bubble", 32'(qc(45) - qc(44)), 32'd1);
      check("c_fd0_time", 32'(fdq.size() > 0 ? fdq[0] : -1), 32'(qc(44) + 1));
      check("c_fd1_time", 32'(fdq.size() > 1 ? fdq[1] : -1), 32'(qc(89) + 1));
      build_frame(2, 0, 24'h0);
      build_frame(2, 0, 24'h0);
      compare_stream("c_bars", 1'b1);
      check("c_after_eop_valid", 32'(dv[2]), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("c_idle_valid", 32'(dv[2]), 32'd0);
      check("c_fd_pulses", 32'(fdq.size()), 32'd2);

      // ---- solid colour latched per frame, random backpressure ----
      clear_mon();
      psel[2]  = 2'd1;
      solid[2] = 24'h123456;
      en[2]    = 1'b1;
      @(posedge clk); #1;
      check("s_restart_valid", 32'(dv[2]), 32'd1);
      check("s_restart_beat", mk(dsop[2], deop[2], dd[2]), mk(1'b1, 1'b0, 24'h00000F));
      solid[2] = 24'hABCDEF;
      run_until(2, 50, 2000, 1'b1);
      build_frame(2, 1, 24'h123456);
      build_frame(2, 1, 24'hABCDEF);
      compare_stream("solid", 1'b1);

      // ---- reset mid video packet, then restart with checkerboard ----
      clear_mon();
      psel[2] = 2'd3;
      en[2]   = 1'b1;
      for (int k = 0; k < 100 && q.size() < 12; k++) begin
         @(posedge clk); #1;
      end
      check("r_reached_video", 32'(q.size() >= 12), 32'd1);
      rst_n[2] = 1'b0;
      @(posedge clk); #1;
      check("r_valid", 32'(dv[2]), 32'd0);
      check("r_data", 32'(dd[2]), 32'd0);
      check("r_flags", 32'({dsop[2], deop[2], fd[2]}), 32'd0);
      clear_mon();
      rst_n[2] = 1'b1;
      @(posedge clk); #1;
      check("r_restart_beat", mk(dsop[2], deop[2], dd[2]), mk(1'b1, 1'b0, 24'h00000F));
      check("r_restart_valid", 32'(dv[2]), 32'd1);
      run_until(1, 10, 400, 1'b0);
      build_frame(2, 3, 24'h0);
      compare_stream("checker", 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/avst_tpg_source.md
# avst_tpg_source

Avalon-ST video test-pattern source that generates complete frames for the video pipeline. Each frame is one control packet carrying width, height and interlace, followed by one video packet of WIDTH×HEIGHT 24-bit pixels. It sits directly upstream of the control-packet override stage and drives its sink interface. It honours downstream backpressure with ready latency 0.

## Interface
- WIDTH, 640, active pixels per line (8..65535)
- HEIGHT, 480, active lines per frame (1..65535)
- INTERLACE, 4'h3, interlace nibble placed in the control packet
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- enable  in  1  frame generation enable; sampled only at frame boundaries
- pattern_sel  in  2  0 colour bars, 1 solid, 2 horizontal ramp, 3 checkerboard; latched at frame start
- solid_color  in  24  pixel value for pattern 1; latched at frame start
- dout_data  out  24  beat data
- dout_valid  out  1  beat valid
- dout_startofpacket  out  1  first beat of packet
- dout_endofpacket  out  1  last beat of packet
- dout_ready  in  1  sink ready (latency 0)
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- All outputs are registered. In reset: dout_valid=0, dout_data=0, sop=0, eop=0, frame_done=0, state IDLE, x=y=0.
- A beat is accepted on any edge with dout_valid=1 and dout_ready=1. Data, sop and eop stay stable while valid=1 and ready=0. The block never deasserts valid mid-packet.
- States: IDLE → CTRL_HDR → CTRL_B0 → CTRL_B1 → CTRL_B2 → VID_HDR → VID_PIX → (CTRL_HDR | IDLE).
- CTRL_HDR: data 24'h00000F, sop=1.
- CTRL_B0: {w[7:4],w[11:8],w[15:12]}, with each field zero-extended to 8 bits.
- CTRL_B1: {h[11:8],h[15:12],w[3:0]}.
- CTRL_B2: {INTERLACE,h[3:0],h[7:4]}, eop=1.
- With 640×480 and INTERLACE=3, the control beats are 00000F, 080200, 010000, 03000E.
- VID_HDR: data 24'h000000, sop=1.
- VID_PIX: x counts 0..WIDTH-1, then wraps to 0 and y increments. eop=1 on pixel (WIDTH-1, HEIGHT-1).
- Patterns, with bits [23:16]/[15:8]/[7:0] = R/G/B:
  - 0, colour bars: BARW=WIDTH/8 (integer division). Bar index increments every BARW pixels and saturates at 7, so bar 7 absorbs the remainder. Bar order is FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Use a bar counter; no divider in the datapath.
  - 1, solid: the latched solid_color.
  - 2, ramp: {x[7:0],x[7:0],x[7:0]}.
  - 3, checkerboard: FFFFFF if x[4]^y[4] else 000000.
- Enable handling:
  - In IDLE with enable=1, the next edge loads CTRL_HDR.
  - When the last pixel is accepted with enable=1, the next CTRL_HDR loads on the same edge, so there is no bubble.
  - When the last pixel is accepted with enable=0, valid drops and the state returns to IDLE.
  - Deasserting enable mid-frame has no effect until the frame completes.
- pattern_sel and solid_color are latched on the edge that loads CTRL_HDR. Changes mid-frame are ignored.
- Reset asserted mid-packet aborts immediately to the reset values. The next frame restarts at CTRL_HDR.

## Timing
- The first CTRL_HDR has valid=1 one cycle after enable is sampled high in IDLE.
- Throughput is 1 beat/cycle while dout_ready=1. A frame takes 5+WIDTH×HEIGHT accepted beats.
- frame_done is asserted in the cycle after the last pixel is accepted, for exactly one cycle.
- Counter widths: x and y are 16 bits and the bar counter is 16 bits. No overflow is possible within the legal parameter range.

## Test plan
- 640×480, enable=1, ready=1, after reset release → beats 00000F, 080200, 010000, 03000E, then 000000 with sop, then 307200 pixels. eop on the last pixel. frame_done 1 cycle later. The next CTRL_HDR follows with no bubble.
- WIDTH=8, HEIGHT=2, pattern 0 → each line is FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. WIDTH=20 → bar 7 covers x=14..19.
- Random dout_ready toggling → data, sop and eop are held while stalled. The accepted beat sequence is identical to the ready=1 run. valid never drops mid-packet.
- Pattern 1 with solid_color=123456, changed to ABCDEF mid-frame → all pixels of that frame are 123456. The next frame is ABCDEF.
- enable deasserted during VID_PIX → the frame completes, valid=0 after eop, and the state is IDLE. Reasserting enable gives valid with 00000F one cycle after it is sampled.
- reset=0 asserted mid-video-packet for 1 cycle → the next cycle shows all outputs at reset values. After release with enable=1, the stream restarts at 00000F.
